cpu_io_port: RTL and testbench
==============================

Name: cpu_io_port

Overview:
- CPU-side responder for the accumulator I/O interface. It is the other end of the CPU's INP/OUT strobes, aib (input bus) and aob (output bus).
- Buffers bytes from an external producer into an input FIFO for the CPU to read (INP), and bytes written by the CPU (OUT) into an output FIFO drained by an external consumer.
- The CPU cannot stall, so every CPU access completes in one cycle. Overflow and underrun are recorded in sticky flags, never back-pressured.

Parameters:
- DATA_W, 8, byte width of both buses.
- IN_DEPTH, 4, input FIFO entries; power of 2, >=2.
- OUT_DEPTH, 4, output FIFO entries; power of 2, >=2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- inp_stb_i  in  1  CPU INP strobe (ctrl INP bit); pop input FIFO.
- aib_o  out  DATA_W  to CPU aib; input FIFO head.
- out_stb_i  in  1  CPU OUT strobe (ctrl OUT bit); push aob_i.
- aob_i  in  DATA_W  from CPU aob (accumulator value).
- in_data_i  in  DATA_W  external producer data.
- in_valid_i  in  1  external producer valid.
- in_ready_o  out  1  input FIFO can accept.
- out_data_o  out  DATA_W  external consumer data (output FIFO head).
- out_valid_o  out  1  output FIFO non-empty.
- out_ready_i  in  1  external consumer ready.
- in_count_o  out  clog2(IN_DEPTH+1)  input FIFO occupancy.
- out_count_o  out  clog2(OUT_DEPTH+1)  output FIFO occupancy.
- ovf_o  out  1  sticky: OUT write dropped (output FIFO full).
- unf_o  out  1  sticky: INP read of empty input FIFO.
- clr_i  in  1  synchronous clear of ovf_o/unf_o.

Behaviour:
- Reset (async, any cycle, including mid-transfer): both FIFOs emptied, pointers 0, counts 0, ovf_o=unf_o=0, in_ready_o=1, out_valid_o=0, aib_o=0, out_data_o=0. Stored data is discarded.
- Input FIFO, first-word fall-through:
  - aib_o = head when non-empty, else 8'h00 (combinational from storage/pointer, zero-cycle read latency).
  - Push on edge where in_valid_i & in_ready_o. in_ready_o = !in_full, with no pop bypass: when full, a same-cycle INP does not let a push in.
  - Pop on edge where inp_stb_i & !in_empty.
  - inp_stb_i while empty: no pointer change, aib_o=0, unf_o<=1.
  - Simultaneous push and pop when non-empty and non-full: count unchanged, both pointers advance.
- Output FIFO, first-word fall-through:
  - out_data_o = head when non-empty, else 0. out_valid_o = !out_empty.
  - Pop on edge where out_valid_o & out_ready_i.
  - Push aob_i on edge where out_stb_i, accepted if !out_full OR a pop happens in the same cycle (full + pop + push keeps count = OUT_DEPTH).
  - Otherwise the byte is dropped and ovf_o<=1.
- Pointers wrap modulo depth. Counts saturate only by construction: never exceed depth, never go below 0.
- Sticky flags: set has priority over clr_i in the same cycle; clr_i alone clears next edge.
- CPU-visible latency: byte accepted from external at edge N is on aib_o after edge N. CPU byte from OUT at edge N has out_valid_o=1 after edge N.

Optional Feature:
- Macro IO_PORT_LOOPBACK_EN.
- Defined:
  - Adds port loop_i (in, 1). While loop_i=1, out_stb_i pushes aob_i into the input FIFO instead of the output FIFO, under input-FIFO full rules; when full the byte is dropped and ovf_o set.
  - in_ready_o forced 0. The output FIFO still drains normally.
  - A same-edge pop by inp_stb_i does not free space for the loopback push, matching the external rule.
- Undefined: no loop_i port; behaviour exactly as above.

Decomposition:
- Package io_port_pkg holds:
  - default DATA_W/IN_DEPTH/OUT_DEPTH constants;
  - EMPTY_DATA constant (8'h00) driven on aib_o/out_data_o when empty;
  - a count-width helper function.
- One sub-module, sync_fifo (params WIDTH, DEPTH; FWFT, count, full/empty outputs, push/pop inputs), instantiated twice.
- Top level holds the accept/drop logic, sticky flags and the loopback mux.

Test Plan:
- Reset, then external pushes 8'h11,8'h22,8'h33 -> in_count_o=3 and aib_o=8'h11. Three INP strobes -> aib_o goes 8'h22, 8'h33, 8'h00. unf_o stays 0.
- Fill input FIFO with 4 bytes -> in_ready_o=0. INP and in_valid_i in the same cycle -> pop only, count=3. Next cycle in_ready_o=1.
- OUT 5 bytes (8'hA0..8'hA4) with out_ready_i=0 -> out_count_o=4, ovf_o=1, out_data_o=8'hA0. Assert clr_i -> ovf_o=0.
- Output FIFO full, out_ready_i=1 and OUT 8'hB5 in the same cycle -> count stays 4, tail holds 8'hB5, ovf_o=0. Drain order is preserved.
- INP on empty -> aib_o=8'h00, unf_o=1. Assert rst_i mid-stream with 2 bytes queued in each FIFO -> all counts 0, flags 0, out_valid_o=0 immediately, before the next clock edge.
- (IO_PORT_LOOPBACK_EN) loop_i=1, OUT 8'h5A -> in_count_o=1 and aib_o=8'h5A, out_count_o unchanged, in_ready_o=0.

Source files
------------

// File: rtl/io_port_pkg.sv
// ============================================================================
// Module      : io_port_pkg
// Description : Shared constants and helpers for the CPU accumulator I/O port:
//               default bus width and FIFO depths, the byte driven on the read
//               buses while a FIFO is empty, and the occupancy-count width
//               helper.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_port_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_IN_DEPTH  = 4;
   localparam int DEF_OUT_DEPTH = 4;

   // Value presented on aib_o / out_data_o whenever the backing FIFO is empty
   localparam logic [DEF_DATA_W-1:0] EMPTY_DATA = 8'h00;

   // An occupancy counter must represent 0..depth inclusive
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_io_port_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               visible combinationally on o_head (EMPTY_DATA when empty).
//               A push while full is taken only if a pop happens on the same
//               edge; pops while empty are ignored.
// Ports       : clk, rst (async, active-high)
//               i_push, i_data  - write side
//               i_pop           - read side
//               o_head          - current head (zero-latency)
//               o_count         - occupancy 0..DEPTH
//               o_full, o_empty - status
// Config      : WIDTH, DEPTH (DEPTH a power of 2, >= 2)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
   import io_port_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W,
   parameter int DEPTH = DEF_IN_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_push,
   input  logic [WIDTH-1:0]            i_data,
   input  logic                        i_pop,
   output logic [WIDTH-1:0]            o_head,
   output logic [cnt_width(DEPTH)-1:0] o_count,
   output logic                        o_full,
   output logic                        o_empty
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == c_CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = o_empty ? WIDTH'(EMPTY_DATA) : r_mem[r_rd_ptr];

   assign w_pop  = i_pop & ~o_empty;
   // When full the write slot equals the read slot; it is free only if the
   // head leaves on this same edge.
   assign w_push = i_push & (~o_full | w_pop);

   // Pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset; stale contents are unreachable once pointers clear
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

`default_nettype wire

// File: rtl/cpu_io_port.sv
// ============================================================================
// Module      : cpu_io_port
// Description : CPU-side responder for the accumulator INP/OUT interface.
//               External producer bytes are buffered in an input FIFO read by
//               INP (aib_o); OUT writes (aob_i) are buffered in an output FIFO
//               drained by an external consumer. CPU accesses never stall:
//               dropped OUT writes set ovf_o, INP reads of an empty FIFO set
//               unf_o (both sticky, cleared by clr_i; a set wins over clear).
// Ports       : clk_i, rst_i (async, active-high)
//               inp_stb_i, aib_o          - CPU INP strobe / input bus
//               out_stb_i, aob_i          - CPU OUT strobe / accumulator
//               in_data_i, in_valid_i, in_ready_o    - external producer
//               out_data_o, out_valid_o, out_ready_i - external consumer
//               in_count_o, out_count_o   - FIFO occupancies
//               ovf_o, unf_o, clr_i       - sticky error flags and clear
//               loop_i                    - loopback select (option only)
// Config      : DATA_W, IN_DEPTH, OUT_DEPTH
//               IO_PORT_LOOPBACK_EN - adds loop_i; while high OUT writes go
//               into the input FIFO and the external producer is blocked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_io_port
   import io_port_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int IN_DEPTH  = DEF_IN_DEPTH,
   parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            inp_stb_i,
   output logic [DATA_W-1:0]               aib_o,
   input  logic                            out_stb_i,
   input  logic [DATA_W-1:0]               aob_i,
   input  logic [DATA_W-1:0]               in_data_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   output logic [DATA_W-1:0]               out_data_o,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [cnt_width(IN_DEPTH)-1:0]  in_count_o,
   output logic [cnt_width(OUT_DEPTH)-1:0] out_count_o,
   output logic                            ovf_o,
   output logic                            unf_o,
   input  logic                            clr_i
`ifdef IO_PORT_LOOPBACK_EN
   ,
   input  logic                            loop_i
`endif
);

   logic              w_loop;
   logic              w_in_full;
   logic              w_in_empty;
   logic              w_in_push;
   logic              w_in_pop;
   logic [DATA_W-1:0] w_in_wdata;
   logic              w_out_full;
   logic              w_out_empty;
   logic              w_out_push;
   logic              w_out_pop;
   logic              w_ovf_set;
   logic              w_unf_set;
   logic              r_ovf;
   logic              r_unf;

`ifdef IO_PORT_LOOPBACK_EN
   assign w_loop = loop_i;
`else
   assign w_loop = 1'b0;
`endif

   // Input side: no pop bypass, so a full FIFO refuses pushes even when an
   // INP pops on the same edge. The loopback path obeys the same rule.
   assign in_ready_o = ~w_in_full & ~w_loop;
   assign w_in_pop   = inp_stb_i & ~w_in_empty;
   assign w_in_push  = w_loop ? (out_stb_i & ~w_in_full) : (in_valid_i & in_ready_o);
   assign w_in_wdata = w_loop ? aob_i : in_data_i;

   // Output side: a same-edge drain makes room for an OUT write
   assign out_valid_o = ~w_out_empty;
   assign w_out_pop   = out_ready_i & ~w_out_empty;
   assign w_out_push  = out_stb_i & ~w_loop & (~w_out_full | w_out_pop);

   assign w_ovf_set = out_stb_i & (w_loop ? w_in_full : ~w_out_push);
   assign w_unf_set = inp_stb_i & w_in_empty;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (IN_DEPTH)
   ) u_in_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_push  (w_in_push),
      .i_data  (w_in_wdata),
      .i_pop   (w_in_pop),
      .o_head  (aib_o),
      .o_count (in_count_o),
      .o_full  (w_in_full),
      .o_empty (w_in_empty)
   );

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_push  (w_out_push),
      .i_data  (aob_i),
      .i_pop   (w_out_pop),
      .o_head  (out_data_o),
      .o_count (out_count_o),
      .o_full  (w_out_full),
      .o_empty (w_out_empty)
   );

   // Sticky flags: a new event outranks a clear on the same edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_ovf_set)  r_ovf <= 1'b1;
         else if (clr_i) r_ovf <= 1'b0;
         if (w_unf_set)  r_unf <= 1'b1;
         else if (clr_i) r_unf <= 1'b0;
      end
   end

   assign ovf_o = r_ovf;
   assign unf_o = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_cpu_io_port.sv
// ============================================================================
// Module      : tb_cpu_io_port
// Description : Self-checking bench for cpu_io_port: directed scenarios plus
//               randomized traffic compared against a queue-based model.
// Config      : IO_PORT_LOOPBACK_EN enables the loopback scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_io_port;

   localparam int DW = 8;
   localparam int ID = 4;
   localparam int OD = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          inp_stb_i = 1'b0;
   logic [DW-1:0] aib_o;
   logic          out_stb_i = 1'b0;
   logic [DW-1:0] aob_i = '0;
   logic [DW-1:0] in_data_i = '0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [DW-1:0] out_data_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [2:0]    in_count_o;
   logic [2:0]    out_count_o;
   logic          ovf_o;
   logic          unf_o;
   logic          clr_i = 1'b0;
`ifdef IO_PORT_LOOPBACK_EN
   logic          loop_i = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_io_port #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .inp_stb_i   (inp_stb_i),
      .aib_o       (aib_o),
      .out_stb_i   (out_stb_i),
      .aob_i       (aob_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .in_count_o  (in_count_o),
      .out_count_o (out_count_o),
      .ovf_o       (ovf_o),
      .unf_o       (unf_o),
      .clr_i       (clr_i)
`ifdef IO_PORT_LOOPBACK_EN
      ,
      .loop_i      (loop_i)
`endif
   );

   // ---- stimulus helpers (drive only) ----
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inp_stb_i = 1'b0; out_stb_i = 1'b0; in_valid_i = 1'b0;
      out_ready_i = 1'b0; clr_i = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic ext_push(input logic [7:0] b);
      in_valid_i = 1'b1; in_data_i = b;
      tick();
      in_valid_i = 1'b0;
   endtask

   task automatic cpu_inp();
      inp_stb_i = 1'b1;
      tick();
      inp_stb_i = 1'b0;
   endtask

   task automatic cpu_out(input logic [7:0] b);
      out_stb_i = 1'b1; aob_i = b;
      tick();
      out_stb_i = 1'b0;
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      apply_reset();
      checks += 8;
      if (in_count_o !== 3'd0) begin errors++; $display("FAIL reset_in_count: got %0d expected 0", in_count_o); end
      if (out_count_o !== 3'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count_o); end
      if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
      if (unf_o !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", unf_o); end
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
      if (aib_o !== 8'h00) begin errors++; $display("FAIL reset_aib: got %h expected 00", aib_o); end
      if (out_data_o !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data_o); end
   endtask

   task automatic test_input_fifo();
      logic [7:0] exp_seq [3] = '{8'h22, 8'h33, 8'h00};
      ext_push(8'h11); ext_push(8'h22); ext_push(8'h33);
      checks += 2;
      if (in_count_o !== 3'd3) begin errors++; $display("FAIL in_count3: got %0d expected 3", in_count_o); end
      if (aib_o !== 8'h11) begin errors++; $display("FAIL in_head: got %h expected 11", aib_o); end
      for (int i = 0; i < 3; i++) begin
         cpu_inp();
         checks++;
         if (aib_o !== exp_seq[i]) begin errors++; $display("FAIL inp_seq%0d: got %h expected %h", i, aib_o, exp_seq[i]); end
      end
      checks++;
      if (unf_o !== 1'b0) begin errors++; $display("FAIL inp_no_unf: got %b expected 0", unf_o); end
   endtask

   task automatic test_in_full();
      logic [7:0] exp_seq [3] = '{8'hC1, 8'hC2, 8'hC3};
      for (int i = 0; i < 4; i++) ext_push(8'hC0 + 8'(i));
      checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL in_full_ready: got %b expected 0", in_ready_o); end
      inp_stb_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'hEE;
      tick();
      idle();
      checks += 3;
      if (in_count_o !== 3'd3) begin errors++; $display("FAIL full_pop_only_count: got %0d expected 3", in_count_o); end
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", in_ready_o); end
      if (aib_o !== 8'hC1) begin errors++; $display("FAIL full_pop_head: got %h expected C1", aib_o); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (aib_o !== exp_seq[i]) begin errors++; $display("FAIL full_drain%0d: got %h expected %h", i, aib_o, exp_seq[i]); end
         cpu_inp();
      end
   endtask

   task automatic test_out_ovf();
      out_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) cpu_out(8'hA0 + 8'(i));
      checks += 3;
      if (out_count_o !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", out_count_o); end
      if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf_o); end
      if (out_data_o !== 8'hA0) begin errors++; $display("FAIL ovf_head: got %h expected A0", out_data_o); end
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      checks++;
      if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf_o); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_seq [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB5};
      out_ready_i = 1'b1; out_stb_i = 1'b1; aob_i = 8'hB5;
      tick();
      idle();
      checks += 3;
      if (out_count_o !== 3'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", out_count_o); end
      if (ovf_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", ovf_o); end
      if (out_data_o !== 8'hA1) begin errors++; $display("FAIL b2b_head: got %h expected A1", out_data_o); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_data_o !== exp_seq[i]) begin errors++; $display("FAIL b2b_drain%0d: got %h expected %h", i, out_data_o, exp_seq[i]); end
         out_ready_i = 1'b1;
         tick();
         out_ready_i = 1'b0;
      end
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid_o); end
   endtask

   task automatic test_unf_async_reset();
      cpu_inp();
      checks += 2;
      if (aib_o !== 8'h00) begin errors++; $display("FAIL unf_aib: got %h expected 00", aib_o); end
      if (unf_o !== 1'b1) begin errors++; $display("FAIL unf_set: got %b expected 1", unf_o); end
      for (int i = 0; i < 2; i++) begin
         in_valid_i = 1'b1; in_data_i = 8'h44 + 8'(i);
         out_stb_i = 1'b1; aob_i = 8'h66 + 8'(i);
         tick();
      end
      idle();
      checks += 2;
      if (in_count_o !== 3'd2) begin errors++; $display("FAIL pre_rst_in: got %0d expected 2", in_count_o); end
      if (out_count_o !== 3'd2) begin errors++; $display("FAIL pre_rst_out: got %0d expected 2", out_count_o); end
      @(negedge clk);
      rst_i = 1'b1;
      #1;
      checks += 6;
      if (in_count_o !== 3'd0) begin errors++; $display("FAIL arst_in_count: got %0d expected 0", in_count_o); end
      if (out_count_o !== 3'd0) begin errors++; $display("FAIL arst_out_count: got %0d expected 0", out_count_o); end
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid_o); end
      if (unf_o !== 1'b0) begin errors++; $display("FAIL arst_unf: got %b expected 0", unf_o); end
      if (aib_o !== 8'h00) begin errors++; $display("FAIL arst_aib: got %h expected 00", aib_o); end
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", in_ready_o); end
      #2;
      rst_i = 1'b0;
   endtask

   // Randomized traffic against a queue model of both FIFOs and the flags
   task automatic test_random();
      logic [7:0] in_q[$];
      logic [7:0] out_q[$];
      bit m_ovf = 0, m_unf = 0;
      bit e_in_push, e_in_pop, e_out_push, e_out_pop;
      logic [7:0] e_aib, e_odata;
      apply_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         // alternate fill-heavy and drain-heavy phases to reach both extremes
         bit fill = ((cyc / 50) % 2) == 0;
         in_valid_i  = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         in_data_i   = 8'($urandom);
         inp_stb_i   = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         out_stb_i   = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         aob_i       = 8'($urandom);
         out_ready_i = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr_i       = ($urandom_range(0, 7) == 0);
         #1;
         checks++;
         if (in_ready_o !== (in_q.size() < ID)) begin errors++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", cyc, in_ready_o, in_q.size() < ID); end
         e_in_push  = in_valid_i && (in_q.size() < ID);
         e_in_pop   = inp_stb_i && (in_q.size() > 0);
         e_out_pop  = out_ready_i && (out_q.size() > 0);
         e_out_push = out_stb_i && ((out_q.size() < OD) || e_out_pop);
         if (out_stb_i && !e_out_push) m_ovf = 1;
         else if (clr_i) m_ovf = 0;
         if (inp_stb_i && in_q.size() == 0) m_unf = 1;
         else if (clr_i) m_unf = 0;
         if (e_in_pop)   void'(in_q.pop_front());
         if (e_in_push)  in_q.push_back(in_data_i);
         if (e_out_pop)  void'(out_q.pop_front());
         if (e_out_push) out_q.push_back(aob_i);
         @(posedge clk);
         #1;
         e_aib   = (in_q.size() > 0) ? in_q[0] : 8'h00;
         e_odata = (out_q.size() > 0) ? out_q[0] : 8'h00;
         checks += 7;
         if (in_count_o !== 3'(in_q.size())) begin errors++; $display("FAIL rnd_in_count c%0d: got %0d expected %0d", cyc, in_count_o, in_q.size()); end
         if (out_count_o !== 3'(out_q.size())) begin errors++; $display("FAIL rnd_out_count c%0d: got %0d expected %0d", cyc, out_count_o, out_q.size()); end
         if (aib_o !== e_aib) begin errors++; $display("FAIL rnd_aib c%0d: got %h expected %h", cyc, aib_o, e_aib); end
         if (out_data_o !== e_odata) begin errors++; $display("FAIL rnd_out_data c%0d: got %h expected %h", cyc, out_data_o, e_odata); end
         if (out_valid_o !== (out_q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid c%0d: got %b expected %b", cyc, out_valid_o, out_q.size() > 0); end
         if (ovf_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d: got %b expected %b", cyc, ovf_o, m_ovf); end
         if (unf_o !== m_unf) begin errors++; $display("FAIL rnd_unf c%0d: got %b expected %b", cyc, unf_o, m_unf); end
      end
      idle();
   endtask

`ifdef IO_PORT_LOOPBACK_EN
   task automatic test_loopback();
      apply_reset();
      loop_i = 1'b1;
      cpu_out(8'h5A);
      checks += 4;
      if (in_count_o !== 3'd1) begin errors++; $display("FAIL loop_in_count: got %0d expected 1", in_count_o); end
      if (aib_o !== 8'h5A) begin errors++; $display("FAIL loop_aib: got %h expected 5A", aib_o); end
      if (out_count_o !== 3'd0) begin errors++; $display("FAIL loop_out_count: got %0d expected 0", out_count_o); end
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL loop_in_ready: got %b expected 0", in_ready_o); end
      for (int i = 1; i < 5; i++) cpu_out(8'h5A + 8'(i));
      checks += 3;
      if (in_count_o !== 3'd4) begin errors++; $display("FAIL loop_full_count: got %0d expected 4", in_count_o); end
      if (ovf_o !== 1'b1) begin errors++; $display("FAIL loop_ovf: got %b expected 1", ovf_o); end
      if (aib_o !== 8'h5A) begin errors++; $display("FAIL loop_head_kept: got %h expected 5A", aib_o); end
      loop_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_input_fifo();
      test_in_full();
      test_out_ovf();
      test_back_to_back();
      test_unf_async_reset();
      test_random();
`ifdef IO_PORT_LOOPBACK_EN
      test_loopback();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
